// File: rtl/simon_led_sequencer.sv
// simon_led_sequencer
// LED display engine for the Simon Says game: plays back a captured colour
// sequence with programmable on/gap times, echoes player buttons onto the
// LEDs while idle, and runs an all-LED win/lose flash pattern.
// The packed colour sequence port is called seq_data because "sequence" is a
// reserved word in SystemVerilog and cannot be used as a port name.
// All outputs are registered; next-cycle output values are derived from the
// next-state signals so that each output changes together with the state.
module simon_led_sequencer #(
    parameter int NUM_LEDS    = 4,
    parameter int MAX_LEN     = 16,
    parameter int IDX_W       = $clog2(NUM_LEDS),
    parameter int LEN_W       = $clog2(MAX_LEN + 1),
    parameter int ON_CYCLES   = 8,
    parameter int GAP_CYCLES  = 4,
    parameter int FLASH_COUNT = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [LEN_W-1:0]         seq_len,
    input  logic [MAX_LEN*IDX_W-1:0] seq_data,
    input  logic                     flash_req,
    input  logic                     echo_en,
    input  logic [NUM_LEDS-1:0]      buttons,
    output logic [NUM_LEDS-1:0]      leds,
    output logic                     busy,
    output logic [LEN_W-1:0]         step_index,
    output logic                     display_done,
    output logic                     flash_done
);

    // One phase counter covers both the lit and the dark part of a step.
    localparam int PH_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int FC_W   = $clog2(FLASH_COUNT + 1);

    localparam logic [PH_W-1:0]  ON_LAST    = PH_W'(ON_CYCLES - 1);
    localparam logic [PH_W-1:0]  GAP_LAST   = PH_W'(GAP_CYCLES - 1);
    localparam logic [FC_W-1:0]  PULSE_LAST = FC_W'(FLASH_COUNT - 1);
    localparam logic [LEN_W-1:0] LEN_MAX    = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE,
        SHOW_ON,
        SHOW_GAP,
        FLASH_ON,
        FLASH_OFF
    } state_t;

    state_t                   state_q, state_d;
    logic [PH_W-1:0]          phase_q, phase_d;
    logic [LEN_W-1:0]         step_q, step_d;
    logic [FC_W-1:0]          pulse_q, pulse_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic [MAX_LEN*IDX_W-1:0] seq_q, seq_d;

    logic [LEN_W-1:0]         len_clamped;
    logic                     on_last, gap_last, last_step, last_pulse;
    logic                     display_done_d, flash_done_d;
    logic [IDX_W-1:0]         elem;
    logic [NUM_LEDS-1:0]      elem_onehot;
    logic [NUM_LEDS-1:0]      leds_d;
    logic                     busy_d;
    logic [LEN_W-1:0]         step_index_d;

    // A request longer than the sequence memory plays the whole memory.
    assign len_clamped = (seq_len > LEN_MAX) ? LEN_MAX : seq_len;

    assign on_last    = (phase_q == ON_LAST);
    assign gap_last   = (phase_q == GAP_LAST);
    assign last_step  = ((step_q + LEN_W'(1)) == len_q);
    assign last_pulse = (pulse_q == PULSE_LAST);

    // Next-state logic: flash_req has absolute priority, start only in IDLE.
    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        step_d         = step_q;
        pulse_d        = pulse_q;
        len_d          = len_q;
        seq_d          = seq_q;
        display_done_d = 1'b0;
        flash_done_d   = 1'b0;

        if (flash_req) begin
            // Preempts playback (no display_done) and restarts a running flash.
            state_d = FLASH_ON;
            phase_d = '0;
            pulse_d = '0;
            step_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        seq_d   = seq_data;
                        len_d   = len_clamped;
                        step_d  = '0;
                        phase_d = '0;
                        if (len_clamped == '0) begin
                            // Empty sequence: nothing to show, just acknowledge.
                            display_done_d = 1'b1;
                        end else begin
                            state_d = SHOW_ON;
                        end
                    end
                end

                SHOW_ON: begin
                    if (on_last) begin
                        state_d = SHOW_GAP;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end

                SHOW_GAP: begin
                    if (gap_last) begin
                        phase_d = '0;
                        if (last_step) begin
                            state_d        = IDLE;
                            step_d         = '0;
                            display_done_d = 1'b1;
                        end else begin
                            state_d = SHOW_ON;
                            step_d  = step_q + LEN_W'(1);
                        end
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end

                FLASH_ON: begin
                    if (on_last) begin
                        state_d = FLASH_OFF;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end

                FLASH_OFF: begin
                    if (gap_last) begin
                        phase_d = '0;
                        if (last_pulse) begin
                            state_d      = IDLE;
                            pulse_d      = '0;
                            flash_done_d = 1'b1;
                        end else begin
                            state_d = FLASH_ON;
                            pulse_d = pulse_q + FC_W'(1);
                        end
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end

                default: begin
                    state_d = IDLE;
                    phase_d = '0;
                    step_d  = '0;
                    pulse_d = '0;
                end
            endcase
        end
    end

    // Colour of the step about to be shown; out-of-range colours stay dark.
    always_comb begin
        elem        = seq_d[int'(step_d) * IDX_W +: IDX_W];
        elem_onehot = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            elem_onehot[i] = (int'(elem) == i);
        end
    end

    // Output values for the next cycle, derived from the next state.
    always_comb begin
        leds_d       = '0;
        busy_d       = 1'b0;
        step_index_d = '0;
        unique case (state_d)
            IDLE: begin
                // Echo only when idle in this cycle too, so buttons pressed
                // during the last busy cycle never leak onto the LEDs.
                if ((state_q == IDLE) && echo_en) begin
                    leds_d = buttons;
                end
            end
            SHOW_ON: begin
                leds_d       = elem_onehot;
                busy_d       = 1'b1;
                step_index_d = step_d;
            end
            SHOW_GAP: begin
                busy_d       = 1'b1;
                step_index_d = step_d;
            end
            FLASH_ON: begin
                leds_d = '1;
                busy_d = 1'b1;
            end
            FLASH_OFF: begin
                busy_d = 1'b1;
            end
            default: begin
                leds_d = '0;
            end
        endcase
    end

    // FSM state and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            step_q  <= '0;
            pulse_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            step_q  <= step_d;
            pulse_q <= pulse_d;
        end
    end

    // Sequence and length snapshot taken when a playback is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q <= '0;
            seq_q <= '0;
        end else begin
            len_q <= len_d;
            seq_q <= seq_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leds         <= '0;
            busy         <= 1'b0;
            step_index   <= '0;
            display_done <= 1'b0;
            flash_done   <= 1'b0;
        end else begin
            leds         <= leds_d;
            busy         <= busy_d;
            step_index   <= step_index_d;
            display_done <= display_done_d;
            flash_done   <= flash_done_d;
        end
    end

endmodule

// File: tb/tb_simon_led_sequencer.sv
// Testbench for simon_led_sequencer (NUM_LEDS=4, MAX_LEN=16, ON=2, GAP=1,
// FLASH_COUNT=3). Each vector row holds the inputs for one cycle and the
// outputs expected in the following cycle; expectations go through a queue.
module tb_simon_led_sequencer;

    localparam int NUM_LEDS    = 4;
    localparam int MAX_LEN     = 16;
    localparam int IDX_W       = 2;
    localparam int LEN_W       = 5;
    localparam int ON_CYCLES   = 2;
    localparam int GAP_CYCLES  = 1;
    localparam int FLASH_COUNT = 3;

    // steps {2,0,3}
    localparam logic [31:0] SEQA = 32'h0000_0032;
    // junk written while a playback runs
    localparam logic [31:0] SEQX = 32'hFFFF_FFFF;
    // step k has colour k%4
    localparam logic [31:0] SEQB = 32'hE4E4_E4E4;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     start;
    logic [LEN_W-1:0]         seq_len;
    logic [MAX_LEN*IDX_W-1:0] seq_data;
    logic                     flash_req;
    logic                     echo_en;
    logic [NUM_LEDS-1:0]      buttons;
    logic [NUM_LEDS-1:0]      leds;
    logic                     busy;
    logic [LEN_W-1:0]         step_index;
    logic                     display_done;
    logic                     flash_done;

    simon_led_sequencer #(
        .NUM_LEDS   (NUM_LEDS),
        .MAX_LEN    (MAX_LEN),
        .IDX_W      (IDX_W),
        .LEN_W      (LEN_W),
        .ON_CYCLES  (ON_CYCLES),
        .GAP_CYCLES (GAP_CYCLES),
        .FLASH_COUNT(FLASH_COUNT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .seq_len     (seq_len),
        .seq_data    (seq_data),
        .flash_req   (flash_req),
        .echo_en     (echo_en),
        .buttons     (buttons),
        .leds        (leds),
        .busy        (busy),
        .step_index  (step_index),
        .display_done(display_done),
        .flash_done  (flash_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        fl;
        logic        ec;
        logic [3:0]  btn;
        logic [4:0]  len;
        logic [31:0] seq;
        logic [11:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [11:0] exp_q[$];
    logic [3:0]  play_leds[9];
    int          errors = 0;
    int          checks = 0;

    function automatic logic [11:0] outv(input logic [3:0] l, input logic b,
                                         input logic [4:0] s, input logic dd,
                                         input logic fd);
        return {l, b, s, dd, fd};
    endfunction

    task automatic add(input logic st, input logic fl, input logic ec,
                       input logic [3:0] btn, input logic [4:0] len,
                       input logic [31:0] sq, input logic [3:0] l, input logic b,
                       input logic [4:0] s, input logic dd, input logic fd);
        vec_t v;
        v.st  = st;
        v.fl  = fl;
        v.ec  = ec;
        v.btn = btn;
        v.len = len;
        v.seq = sq;
        v.exp = outv(l, b, s, dd, fd);
        tbl.push_back(v);
    endtask

    task automatic compare(input string name, input logic [11:0] want);
        logic [11:0] got;
        got = {leds, busy, step_index, display_done, flash_done};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got leds=%b busy=%b step=%0d done=%b flash_done=%b, expected leds=%b busy=%b step=%0d done=%b flash_done=%b",
                     name, got[11:8], got[7], got[6:2], got[1], got[0],
                     want[11:8], want[7], want[6:2], want[1], want[0]);
        end
    endtask

    // Drive one cycle of inputs, then compare the outputs after the edge.
    task automatic run_row(input vec_t v, input string name);
        start     = v.st;
        flash_req = v.fl;
        echo_en   = v.ec;
        buttons   = v.btn;
        seq_len   = v.len;
        seq_data  = v.seq;
        exp_q.push_back(v.exp);
        @(posedge clk);
        #1;
        start     = 1'b0;
        flash_req = 1'b0;
        compare(name, exp_q.pop_front());
    endtask

    // Plain playback of SEQA from IDLE through display_done.
    task automatic play_a(input string tag);
        vec_t v;
        v.fl  = 1'b0;
        v.ec  = 1'b0;
        v.btn = '0;
        v.len = 5'd3;
        v.seq = SEQA;
        for (int i = 0; i < 9; i++) begin
            v.st  = (i == 0);
            v.exp = outv(play_leds[i], 1'b1, 5'(i / 3), 1'b0, 1'b0);
            run_row(v, $sformatf("%s[%0d]", tag, i));
        end
        v.st  = 1'b0;
        v.exp = outv(4'b0000, 1'b0, 5'd0, 1'b1, 1'b0);
        run_row(v, $sformatf("%s_done", tag));
        v.exp = outv(4'b0000, 1'b0, 5'd0, 1'b0, 1'b0);
        run_row(v, $sformatf("%s_after", tag));
    endtask

    initial begin
        vec_t v;

        play_leds = '{4'b0100, 4'b0100, 4'b0000, 4'b0001, 4'b0001, 4'b0000,
                      4'b1000, 4'b1000, 4'b0000};

        // ---- vector table ----
        // echo in IDLE, one cycle latency
        add(0,0,1,4'b0010,5'd0,SEQA, 4'b0010,0,5'd0,0,0);
        add(0,0,1,4'b1001,5'd0,SEQA, 4'b1001,0,5'd0,0,0);
        add(0,0,0,4'b1001,5'd0,SEQA, 4'b0000,0,5'd0,0,0);
        // playback {2,0,3}; buttons, busy start and sequence changes ignored
        add(1,0,1,4'b1111,5'd3,SEQA, 4'b0100,1,5'd0,0,0);
        add(0,0,1,4'b1111,5'd3,SEQX, 4'b0100,1,5'd0,0,0);
        add(0,0,1,4'b1111,5'd3,SEQX, 4'b0000,1,5'd0,0,0);
        add(1,0,1,4'b1111,5'd1,SEQX, 4'b0001,1,5'd1,0,0);
        add(0,0,1,4'b1111,5'd3,SEQX, 4'b0001,1,5'd1,0,0);
        add(0,0,1,4'b1111,5'd3,SEQX, 4'b0000,1,5'd1,0,0);
        add(1,0,1,4'b1111,5'd3,SEQX, 4'b1000,1,5'd2,0,0);
        add(0,0,1,4'b1111,5'd3,SEQX, 4'b1000,1,5'd2,0,0);
        add(0,0,1,4'b1111,5'd3,SEQX, 4'b0000,1,5'd2,0,0);
        add(0,0,1,4'b1111,5'd3,SEQX, 4'b0000,0,5'd0,1,0);
        // start accepted in the display_done cycle, zero length
        add(1,0,0,4'b1111,5'd0,SEQA, 4'b0000,0,5'd0,1,0);
        add(0,0,0,4'b0000,5'd0,SEQA, 4'b0000,0,5'd0,0,0);
        // flash preempts playback at step 1
        add(1,0,0,4'b0000,5'd3,SEQA, 4'b0100,1,5'd0,0,0);
        add(0,0,0,4'b0000,5'd3,SEQA, 4'b0100,1,5'd0,0,0);
        add(0,0,0,4'b0000,5'd3,SEQA, 4'b0000,1,5'd0,0,0);
        add(0,0,0,4'b0000,5'd3,SEQA, 4'b0001,1,5'd1,0,0);
        add(0,1,0,4'b0000,5'd3,SEQA, 4'b1111,1,5'd0,0,0);
        add(0,0,0,4'b0000,5'd3,SEQA, 4'b1111,1,5'd0,0,0);
        add(0,0,0,4'b0000,5'd3,SEQA, 4'b0000,1,5'd0,0,0);
        for (int p = 0; p < 2; p++) begin
            add(0,0,0,4'b0000,5'd3,SEQA, 4'b1111,1,5'd0,0,0);
            add(0,0,0,4'b0000,5'd3,SEQA, 4'b1111,1,5'd0,0,0);
            add(0,0,0,4'b0000,5'd3,SEQA, 4'b0000,1,5'd0,0,0);
        end
        add(0,0,0,4'b0000,5'd3,SEQA, 4'b0000,0,5'd0,0,1);
        for (int i = 0; i < 3; i++) begin
            add(0,0,0,4'b0000,5'd3,SEQA, 4'b0000,0,5'd0,0,0);
        end
        // start and flash together: flash only; then a restart mid-pattern
        add(1,1,0,4'b0000,5'd3,SEQA, 4'b1111,1,5'd0,0,0);
        add(0,0,0,4'b0000,5'd3,SEQA, 4'b1111,1,5'd0,0,0);
        add(0,0,0,4'b0000,5'd3,SEQA, 4'b0000,1,5'd0,0,0);
        add(0,1,0,4'b0000,5'd3,SEQA, 4'b1111,1,5'd0,0,0);
        add(0,0,0,4'b0000,5'd3,SEQA, 4'b1111,1,5'd0,0,0);
        add(0,0,0,4'b0000,5'd3,SEQA, 4'b0000,1,5'd0,0,0);
        for (int p = 0; p < 2; p++) begin
            add(0,0,0,4'b0000,5'd3,SEQA, 4'b1111,1,5'd0,0,0);
            add(0,0,0,4'b0000,5'd3,SEQA, 4'b1111,1,5'd0,0,0);
            add(0,0,0,4'b0000,5'd3,SEQA, 4'b0000,1,5'd0,0,0);
        end
        add(0,0,0,4'b0000,5'd3,SEQA, 4'b0000,0,5'd0,0,1);
        add(0,0,0,4'b0000,5'd3,SEQA, 4'b0000,0,5'd0,0,0);

        // ---- reset state ----
        reset     = 1'b1;
        start     = 1'b0;
        flash_req = 1'b0;
        echo_en   = 1'b0;
        buttons   = '0;
        seq_len   = '0;
        seq_data  = '0;
        #1 reset = 1'b0;
        #2 compare("reset_async", outv(4'b0000, 1'b0, 5'd0, 1'b0, 1'b0));
        @(posedge clk);
        #1 compare("reset_held", outv(4'b0000, 1'b0, 5'd0, 1'b0, 1'b0));
        #2 reset = 1'b1;

        // ---- table ----
        foreach (tbl[i]) begin
            run_row(tbl[i], $sformatf("vec%0d", i));
        end

        // ---- seq_len=20 clamps to 16 steps ----
        v.fl  = 1'b0;
        v.ec  = 1'b0;
        v.btn = '0;
        v.len = 5'd20;
        v.seq = SEQB;
        for (int k = 0; k < 16; k++) begin
            for (int c = 0; c < 3; c++) begin
                v.st  = (k == 0 && c == 0);
                v.exp = outv((c < 2) ? 4'(1 << (k % 4)) : 4'b0000, 1'b1,
                             5'(k), 1'b0, 1'b0);
                run_row(v, $sformatf("clamp_k%0d_c%0d", k, c));
            end
        end
        v.st  = 1'b0;
        v.exp = outv(4'b0000, 1'b0, 5'd0, 1'b1, 1'b0);
        run_row(v, "clamp_done");
        v.exp = outv(4'b0000, 1'b0, 5'd0, 1'b0, 1'b0);
        run_row(v, "clamp_after");

        // ---- asynchronous reset during SHOW_ON, then replay from step 0 ----
        v.st  = 1'b1;
        v.len = 5'd3;
        v.seq = SEQA;
        v.exp = outv(4'b0100, 1'b1, 5'd0, 1'b0, 1'b0);
        run_row(v, "rst_pre");
        #2 reset = 1'b0;
        #1 compare("rst_mid_async", outv(4'b0000, 1'b0, 5'd0, 1'b0, 1'b0));
        @(posedge clk);
        #1 compare("rst_mid_held", outv(4'b0000, 1'b0, 5'd0, 1'b0, 1'b0));
        #2 reset = 1'b1;
        play_a("replay");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
